// File: rtl/risc_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Forward mux selects and the MDU sequencer state type.
package risc_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        MDU_IDLE,
        MDU_BUSY
    } mdu_state_e;

endpackage

// File: rtl/mdu_stall_fsm.sv
// Multi-cycle execute sequencer: keeps an MDU instruction in E
// for MDU_LATENCY cycles.
// Ports: clk, rst (sync, active-low), start (MduStartE),
//        mdu_stall (hold F/D/E, bubble M), mdu_busy (FSM in BUSY).
module mdu_stall_fsm
    import risc_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic mdu_stall,
    output logic mdu_busy
);

    localparam int CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT =
        CW'((MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        unique case (state_q)
            MDU_IDLE: begin
                if (start && (MDU_LATENCY > 1)) begin
                    mdu_stall = 1'b1;
                    state_d   = MDU_BUSY;
                    cnt_d     = CNT_INIT;
                end
            end
            MDU_BUSY: begin
                // cnt==0 is the last cycle in E: release the stall
                if (cnt_q != '0) begin
                    mdu_stall = 1'b1;
                    cnt_d     = cnt_q - CW'(1);
                end else begin
                    state_d = MDU_IDLE;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
        if (!rst) begin
            mdu_stall = 1'b0;
        end
    end

    assign mdu_busy = rst && (state_q == MDU_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: E-stage
// forwarding, load-use / RAW stall, branch flush, MDU stall, counters.
// Ports: register indices and write enables per stage, ResultSrcE,
//        PCSrcE, MduStartE in; Stall*/Flush*, Forward*E, MduBusy,
//        StallCount, FlushCount out.
module pipeline_hazard_ctrl
    import risc_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32,
    parameter int FWD_EN      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  ResultSrcE,
    input  logic                  PCSrcE,
    input  logic                  MduStartE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MduBusy,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount
);

    logic             mdu_stall;
    logic             lw_stall;
    logic             raw_stall;
    logic             hz_stall;
    logic             flush_acc;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    mdu_stall_fsm #(
        .MDU_LATENCY(MDU_LATENCY)
    ) u_mdu (
        .clk      (clk),
        .rst      (rst),
        .start    (MduStartE),
        .mdu_stall(mdu_stall),
        .mdu_busy (MduBusy)
    );

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs
    );
        if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
            return FWD_MEM;
        end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    function automatic logic d_match(
        input logic [REG_ADDR_W-1:0] rd
    );
        return (rd != '0) && ((rd == Rs1D) || (rd == Rs2D));
    endfunction

    always_comb begin
        lw_stall  = ResultSrcE && d_match(RdE);
        // W needs no check: the register file is write-first
        raw_stall = (FWD_EN == 0) &&
                    ((RegWriteE && d_match(RdE)) ||
                     (RegWriteM && d_match(RdM)));
        hz_stall  = lw_stall || raw_stall;
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = (FWD_EN != 0) ? fwd_sel(Rs1E) : FWD_REG;
        ForwardBE = (FWD_EN != 0) ? fwd_sel(Rs2E) : FWD_REG;
        flush_acc = 1'b0;
        if (!rst) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            ForwardAE = FWD_REG;
            ForwardBE = FWD_REG;
        end else if (mdu_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else begin
            StallF    = hz_stall;
            StallD    = hz_stall;
            FlushE    = hz_stall || PCSrcE;
            FlushD    = PCSrcE;
            flush_acc = PCSrcE;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_acc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule
